// File: rtl/clk_gen_pkg.sv
// Shared constants for the clk-domain enable/divider generators.
package clk_gen_pkg;
  localparam int          CNT_W_DEF       = 16;
  localparam int          F_CLK_HZ        = 100_000_000;
  localparam int          F_DEF_OUT_HZ    = 1_000;
  localparam logic [15:0] DEFAULT_DIV_DEF = 16'(F_CLK_HZ / (2 * F_DEF_OUT_HZ));
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/shadow divisor, output and tick flops.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] next_div;
  logic             active;
  logic             term;

  // shadow equals div_act whenever nothing is pending, so it is always the value to load
  always_comb begin
    active   = en && (div_act != '0);
    term     = active && (cnt == div_act - 1'b1);
    next_div = wr ? wr_div : shadow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_act <= DEFAULT_DIV;
      shadow  <= DEFAULT_DIV;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (restart || !active) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      div_act <= next_div;
      shadow  <= next_div;
      pend    <= 1'b0;
    end else if (term) begin
      cnt     <= '0;
      div_act <= next_div;
      shadow  <= next_div;
      pend    <= 1'b0;
      // a zero divisor parks the output low; only a falling edge earns a tick
      if (next_div == '0) begin
        clk_out <= 1'b0;
        tick    <= clk_out;
      end else begin
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
      if (wr) begin
        shadow <= wr_div;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable square-wave / tick generators sharing a phase-align restart.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int               N_CH        = 4,
  parameter int               CH_W        = 2,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             sync_restart,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pend
);

  logic [N_CH-1:0] wr_sel;

  // out-of-range channel indices match no channel and are dropped
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = wr_en && (wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[g]),
      .restart (sync_restart),
      .wr      (wr_sel[g]),
      .wr_div  (wr_div),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a down-counting reference model predicts every cycle.
module tb_clk_div_bank;
  localparam int N_CH  = 4;
  localparam int CH_W  = 3;
  localparam int CNT_W = 16;
  localparam int DEF   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_CH-1:0]  ch_en = '0;
  logic             sync_restart = 1'b0;
  logic             wr_en = 1'b0;
  logic [CH_W-1:0]  wr_ch = '0;
  logic [CNT_W-1:0] wr_div = '0;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  clk_div_bank #(
    .N_CH        (N_CH),
    .CH_W        (CH_W),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (16'(DEF))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_div       (wr_div),
    .clk_out      (clk_out),
    .tick         (tick),
    .pend         (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] o;
    logic [N_CH-1:0] t;
    logic [N_CH-1:0] p;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state: rem = cycles left in the current half-period
  int m_div[N_CH];
  int m_sh[N_CH];
  int m_rem[N_CH];
  bit m_pend[N_CH];
  bit m_out[N_CH];
  bit m_tick[N_CH];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    for (int i = 0; i < N_CH; i++) begin
      bit w, idle;
      int nd;
      if (reset) begin
        m_div[i] = DEF; m_sh[i] = DEF; m_rem[i] = DEF;
        m_pend[i] = 0; m_out[i] = 0; m_tick[i] = 0;
      end else begin
        w    = wr_en && (int'(wr_ch) == i);
        idle = sync_restart || !ch_en[i] || (m_div[i] == 0);
        if (idle || m_rem[i] == 1) begin
          nd = w ? int'(wr_div) : (m_pend[i] ? m_sh[i] : m_div[i]);
          m_div[i] = nd; m_sh[i] = nd; m_pend[i] = 0; m_rem[i] = nd;
          if (idle) begin
            m_out[i] = 0; m_tick[i] = 0;
          end else if (nd == 0) begin
            m_tick[i] = m_out[i]; m_out[i] = 0;
          end else begin
            m_out[i] = !m_out[i]; m_tick[i] = 1;
          end
        end else begin
          m_rem[i]--;
          m_tick[i] = 0;
          if (w) begin
            m_sh[i] = int'(wr_div); m_pend[i] = 1;
          end
        end
      end
      e.o[i] = m_out[i];
      e.t[i] = m_tick[i];
      e.p[i] = m_pend[i];
    end
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("clk_out", 32'(clk_out), 32'(e.o));
    chk("tick", 32'(tick), 32'(e.t));
    chk("pend", 32'(pend), 32'(e.p));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = CNT_W'(d);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, prev, run_len, min_run, seen, r1, r2, rise;
    bit acc;

    // 1: reset state, then ch0 alone at the default divisor of 5
    run(2);
    chk("rst_out", 32'(clk_out), 0);
    chk("rst_pend", 32'(pend), 0);
    reset = 1'b0;
    ch_en = 4'b0001;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cnt += int'(tick[0]);
      chk("t1_others", 32'(clk_out[3:1] | tick[3:1]), 0);
    end
    chk("t1_ticks", 32'(cnt), 4);

    // 2: shrink ch0 to 3 mid-half-period
    run(2);
    write(0, 3);
    chk("t2_pend", 32'(pend[0]), 1);
    prev = int'(clk_out[0]); run_len = 0; min_run = 1000; seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      run_len++;
      if (int'(clk_out[0]) != prev) begin
        if (seen > 0 && run_len < min_run) min_run = run_len;
        seen++;
        run_len = 0;
        prev = int'(clk_out[0]);
      end
    end
    chk("t2_min_run", 32'(min_run), 3);

    // 3: write ch1 exactly on its terminal cycle
    ch_en = 4'b0011;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (m_rem[1] == 1) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("t3_found_term", 32'(seen), 1);
    write(1, 2);
    chk("t3_pend1", 32'(pend[1]), 0);
    chk("t3_tick1", 32'(tick[1]), 1);
    run(12);

    // 4: staggered divisors, then phase-align restart
    ch_en = 4'b1111;
    write(0, 4); run(1);
    write(1, 4); run(2);
    write(2, 6); run(3);
    write(3, 4); run(1);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("t4_restart", 32'(clk_out), 0);
    run(4);
    chk("t4_rise4", 32'(clk_out), 32'b1011);
    run(2);
    chk("t4_rise6", 32'(clk_out), 32'b1111);
    run(10);

    // 5: park ch2 with D=0, revive with 7, out-of-range writes
    write(2, 0);
    run(14);
    acc = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      acc |= clk_out[2] | tick[2];
    end
    chk("t5_idle", 32'(acc), 0);
    write(2, 7);
    prev = int'(clk_out[2]); r1 = -1; r2 = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (prev == 0 && clk_out[2]) begin
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      prev = int'(clk_out[2]);
    end
    chk("t5_period", 32'(r2 - r1), 14);
    write(4, 1);
    write(7, 2);
    chk("t5_badch_pend", 32'(pend), 0);
    run(10);

    // 6: async reset with a pending write, then enable gap on ch0
    for (int k = 0; k < 10; k++) begin
      if (m_rem[0] > 2) break;
      step();
    end
    write(0, 9);
    chk("t6_pend_set", 32'(pend[0]), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_areset_out", 32'(clk_out), 0);
    chk("t6_areset_tick", 32'(tick), 0);
    chk("t6_areset_pend", 32'(pend), 0);
    run(2);
    reset = 1'b0;
    run(12);
    ch_en[0] = 1'b0;
    run(3);
    chk("t6_dis", 32'(clk_out[0]), 0);
    ch_en[0] = 1'b1;
    rise = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (clk_out[0]) begin
        rise = k;
        break;
      end
    end
    chk("t6_first_rise", 32'(rise), DEF);
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Multi-channel programmable clock-enable generator. It is the parametrised successor to the fixed single-output 100 MHz -> 1 kHz divider. It produces N_CH independent square-wave outputs plus single-cycle tick strobes from clk. Each channel has a runtime-writable half-period, applied glitch-free at the channel's next terminal count, and all channels share a global phase-align restart. Consumers are the display scan, debounce and timer logic in the same clk domain.

Parameters:
N_CH, 4, number of divider channels (1..16)
CH_W, 2, width of channel select; must satisfy 2**CH_W >= N_CH
CNT_W, 16, counter and divisor width
DEFAULT_DIV, 16'd50000, half-period loaded at reset into every channel (100 MHz -> 1 kHz)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
ch_en  in  N_CH  per-channel run enable, level
sync_restart  in  1  one-cycle pulse; restarts all channels in phase
wr_en  in  1  divisor write strobe
wr_ch  in  CH_W  channel index for the write
wr_div  in  CNT_W  new half-period D, in clk cycles
clk_out  out  N_CH  divided square wave per channel
tick  out  N_CH  one-cycle pulse coinciding with every clk_out toggle
pend  out  N_CH  1 = written divisor not yet applied

Behaviour:
- Reset (async, any time, including mid-period): cnt=0, div_act=shadow=DEFAULT_DIV, clk_out=0, tick=0, pend=0.
- Per-channel state: cnt[CNT_W], div_act, shadow, pend, out. Every output is a registered flop with no combinational path from inputs.
- Running (ch_en[i]=1 and div_act!=0):
  - Each cycle, cnt increments.
  - Terminal event when cnt==div_act-1: next cycle cnt=0, clk_out toggles, tick=1 for exactly that cycle.
  - Output period is 2*D cycles with 50% duty. D=1 gives clk_out toggling every cycle and tick held high continuously.
- Terminal event with pend=1: div_act<=shadow and pend<=0 in the same edge, so the next half-period uses the new D. No runt or short pulse is allowed.
- Write (wr_en=1, wr_ch<N_CH): shadow[wr_ch]<=wr_div, pend<=1.
  - wr_ch>=N_CH: write ignored, no state change.
  - Write in the same cycle as that channel's terminal event: wr_div is applied directly (div_act<=wr_div, pend=0).
  - Back-to-back writes before a terminal event: the last write wins.
- ch_en[i]=0:
  - cnt held 0, clk_out=0, tick=0.
  - Writes are still accepted. A pending value is applied immediately while disabled: div_act<=shadow, pend=0 on the next edge.
  - On re-enable, the first toggle (0->1) occurs with its tick D cycles after the first enabled edge.
- div_act==0: channel idle, same outputs as disabled. A later write of nonzero D while idle is applied immediately.
- sync_restart=1, all channels in the same cycle:
  - cnt=0, clk_out=0, tick=0.
  - pending shadow applied (div_act<=shadow, pend=0).
  - A same-cycle write to channel k is applied to k directly.
  - After the restart, channels with equal D run exactly in phase.
- Priority: reset > sync_restart > terminal event/write > count.
- Arithmetic: all compares at CNT_W bits unsigned; the counter never exceeds div_act-1.
- Latency: write to effect is at most D cycles (next terminal event). sync_restart to first tick is D+1 edges.

Decomposition:
- Package clk_gen_pkg: CNT_W default, DEFAULT_DIV, and the localparam for 100 MHz input frequency.
- Sub-module clk_div_chan: one channel holding cnt, div_act, shadow, pend, out and tick. The top instantiates N_CH copies via generate, decodes wr_ch into per-channel write strobes, and fans out sync_restart.

Test Plan:
1. Reset, ch_en=4'b0001, DEFAULT_DIV overridden to 5 -> clk_out[0] period 10 cycles; tick[0] high 1 cycle every 5; other channels stay 0.
2. Ch0 running at D=5, write wr_ch=0 wr_div=3 mid-half-period -> pend[0]=1 until the next terminal event; current half-period completes at 5, subsequent half-periods are 3; no pulse shorter than 3.
3. Write wr_ch=1 wr_div=2 in the exact cycle of channel 1's terminal event -> next half-period is 2, pend[1] never asserts.
4. Channels 0-3 at D=4, D=4, D=6, D=4, staggered; pulse sync_restart -> all clk_out=0; ch0, ch1 and ch3 rise together 4 cycles later; ch2 rises at 6.
5. Write wr_div=0 to channel 2 -> after the terminal event clk_out[2]=0 and tick[2]=0 indefinitely; write 7 -> resumes with a 14-cycle period. Write wr_ch=4 with N_CH=4 -> no state change.
6. Assert reset mid-half-period with pend=1 -> all outputs 0 asynchronously and div_act back to DEFAULT_DIV; drop ch_en[0] for 3 cycles -> clk_out[0]=0, then the first rise is D cycles after re-enable.
